// File: rtl/gray_counter_n_pkg.sv
// Shared constants and Gray/binary helpers for the Gray counter family.
// Helpers operate on MAX_WIDTH-wide values. Zero-extend narrower
// operands; the upper zero bits do not disturb the conversion.
package gray_pkg;

   localparam int MAX_WIDTH = 16;

   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   // b ^ (b >> 1), one bit at a time
   function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
      logic [MAX_WIDTH-1:0] g;
      g[MAX_WIDTH-1] = b[MAX_WIDTH-1];
      for (int i = 0; i < MAX_WIDTH-1; i++)
         g[i] = b[i] ^ b[i+1];
      return g;
   endfunction

   // each binary bit is the XOR of all Gray bits at or above it
   function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
      logic [MAX_WIDTH-1:0] b;
      b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
      for (int i = MAX_WIDTH-2; i >= 0; i--)
         b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

endpackage

// File: rtl/gray_counter_n_if.sv
// Control/status bundle of the Gray counter.
// The master drives the controls. The slave (the counter) returns the count and flags.
interface gray_counter_n_if #(
   parameter int WIDTH = 3
);
   logic             En;
   logic             Up;
   logic             Load;
   logic [WIDTH-1:0] LoadVal;
   logic             ClrOvf;
   logic [WIDTH-1:0] Output;
   logic             Overflow;
   logic             Wrap;

   modport master (
      output En, Up, Load, LoadVal, ClrOvf,
      input  Output, Overflow, Wrap
   );

   modport slave (
      input  En, Up, Load, LoadVal, ClrOvf,
      output Output, Overflow, Wrap
   );
endinterface

// File: rtl/gray_counter_n_gray2bin.sv
// Combinational Gray-to-binary converter of arbitrary width.
module gray2bin_n #(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   // Prefix XOR from the MSB down, accumulated in a local variable
   always_comb begin
      logic [WIDTH-1:0] acc;
      acc = '0;
      acc[WIDTH-1] = gray[WIDTH-1];
      for (int i = WIDTH-2; i >= 0; i--)
         acc[i] = acc[i+1] ^ gray[i];
      bin = acc;
   end

endmodule

// File: rtl/gray_counter_n.sv
// N-bit up/down Gray counter with parallel load, wrap or saturate mode,
// sticky overflow and a one-cycle wrap pulse. Count, flag and pulse
// are all registered.
module gray_counter_n
   import gray_pkg::*;
#(
   parameter int WIDTH    = 3,
   parameter int SATURATE = MODE_WRAP
) (
   input  logic                Clk,
   input  logic                Reset,
   gray_counter_n_if.slave     bus
);

   localparam logic [WIDTH-1:0] TOP = '1;

   if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("gray_counter_n: WIDTH out of range 2..16");
   end

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] cnt_nxt;
   logic [WIDTH-1:0] load_bin;
   logic             term;

   // Load value arrives in Gray code; the count is kept in binary
   gray2bin_n #(.WIDTH(WIDTH)) u_load_cvt (
      .gray (bus.LoadVal),
      .bin  (load_bin)
   );

   // Next count and terminal-event detection: Load > En > hold
   always_comb begin
      cnt_nxt = cnt;
      term    = 1'b0;
      if (bus.Load) begin
         cnt_nxt = load_bin;
      end else if (bus.En) begin
         if (bus.Up) begin
            if (cnt == TOP) begin
               term    = 1'b1;
               cnt_nxt = (SATURATE == MODE_SAT) ? cnt : '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end else begin
            if (cnt == '0) begin
               term    = 1'b1;
               cnt_nxt = (SATURATE == MODE_SAT) ? cnt : TOP;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
      end
   end

   // Count, Gray output, pulse and sticky flag; a terminal event beats ClrOvf
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         cnt          <= '0;
         bus.Output   <= '0;
         bus.Wrap     <= 1'b0;
         bus.Overflow <= 1'b0;
      end else begin
         cnt        <= cnt_nxt;
         bus.Output <= WIDTH'(bin2gray(MAX_WIDTH'(cnt_nxt)));
         bus.Wrap   <= term;
         if (term)
            bus.Overflow <= 1'b1;
         else if (bus.ClrOvf)
            bus.Overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gray_counter_n.sv
// Directed bench for gray_counter_n in four configurations sharing one clock and reset.
module tb_gray_counter_n;
   import gray_pkg::*;

   logic Clk   = 1'b0;
   logic Reset = 1'b0;
   int   ntest = 0;
   int   nfail = 0;

   always #5 Clk = ~Clk;

   gray_counter_n_if #(.WIDTH(3)) if3 ();
   gray_counter_n_if #(.WIDTH(4)) if4 ();
   gray_counter_n_if #(.WIDTH(8)) if8 ();
   gray_counter_n_if #(.WIDTH(5)) if5 ();

   gray_counter_n #(.WIDTH(3), .SATURATE(MODE_WRAP)) u_d3 (.Clk(Clk), .Reset(Reset), .bus(if3));
   gray_counter_n #(.WIDTH(4), .SATURATE(MODE_SAT))  u_d4 (.Clk(Clk), .Reset(Reset), .bus(if4));
   gray_counter_n #(.WIDTH(8), .SATURATE(MODE_WRAP)) u_d8 (.Clk(Clk), .Reset(Reset), .bus(if8));
   gray_counter_n #(.WIDTH(5), .SATURATE(MODE_WRAP)) u_d5 (.Clk(Clk), .Reset(Reset), .bus(if5));

   logic [4:0] ref5_bin;
   gray2bin_n #(.WIDTH(5)) u_ref5 (.gray(if5.Output), .bin(ref5_bin));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ntest++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // one clock edge, then settle before driving/sampling
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   logic [2:0] up3_exp [9] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111,
                               3'b101, 3'b100, 3'b000, 3'b001};

   initial begin
      {if3.En, if3.Up, if3.Load, if3.LoadVal, if3.ClrOvf} = '0;
      {if4.En, if4.Up, if4.Load, if4.LoadVal, if4.ClrOvf} = '0;
      {if8.En, if8.Up, if8.Load, if8.LoadVal, if8.ClrOvf} = '0;
      {if5.En, if5.Up, if5.Load, if5.LoadVal, if5.ClrOvf} = '0;

      // reset state
      tick();
      chk("rst_out", 32'(if3.Output), 32'h0);
      chk("rst_ovf", 32'(if3.Overflow), 32'h0);
      chk("rst_wrap", 32'(if3.Wrap), 32'h0);
      Reset = 1'b1;

      // up count, wrap mode
      if3.En = 1'b1; if3.Up = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         chk($sformatf("up3_out[%0d]", i), 32'(if3.Output), 32'(up3_exp[i]));
         chk($sformatf("up3_wrap[%0d]", i), 32'(if3.Wrap), (i == 7) ? 32'h1 : 32'h0);
         chk($sformatf("up3_ovf[%0d]", i), 32'(if3.Overflow), (i >= 7) ? 32'h1 : 32'h0);
      end
      if3.En = 1'b0;
      tick();
      chk("idle3_out", 32'(if3.Output), 32'h1);
      chk("idle3_wrap", 32'(if3.Wrap), 32'h0);
      chk("idle3_ovf", 32'(if3.Overflow), 32'h1);

      // down count from reset
      Reset = 1'b0; tick(); Reset = 1'b1;
      if3.En = 1'b1; if3.Up = 1'b0;
      tick();
      chk("dn3_out0", 32'(if3.Output), 32'b100);
      chk("dn3_wrap0", 32'(if3.Wrap), 32'h1);
      chk("dn3_ovf0", 32'(if3.Overflow), 32'h1);
      tick();
      chk("dn3_out1", 32'(if3.Output), 32'b101);
      chk("dn3_wrap1", 32'(if3.Wrap), 32'h0);
      if3.En = 1'b0;

      // saturate: load gray 1001 (binary 14), count up into the ceiling
      if4.Load = 1'b1; if4.LoadVal = 4'b1001;
      tick();
      chk("sat_load", 32'(if4.Output), 32'b1001);
      chk("sat_load_wrap", 32'(if4.Wrap), 32'h0);
      if4.Load = 1'b0; if4.En = 1'b1; if4.Up = 1'b1;
      tick();
      chk("sat_out0", 32'(if4.Output), 32'b1000);
      chk("sat_wrap0", 32'(if4.Wrap), 32'h0);
      chk("sat_ovf0", 32'(if4.Overflow), 32'h0);
      tick();
      chk("sat_out1", 32'(if4.Output), 32'b1000);
      chk("sat_wrap1", 32'(if4.Wrap), 32'h1);
      chk("sat_ovf1", 32'(if4.Overflow), 32'h1);
      tick();
      chk("sat_out2", 32'(if4.Output), 32'b1000);
      chk("sat_wrap2", 32'(if4.Wrap), 32'h1);
      if4.En = 1'b0;
      tick();
      chk("sat_idle_wrap", 32'(if4.Wrap), 32'h0);
      chk("sat_idle_ovf", 32'(if4.Overflow), 32'h1);

      // priority: Load beats En (d3 currently binary 6, gray 101, ovf set)
      if3.Load = 1'b1; if3.En = 1'b1; if3.Up = 1'b1; if3.LoadVal = 3'b110;
      tick();
      chk("pri_load", 32'(if3.Output), 32'b110);
      chk("pri_load_wrap", 32'(if3.Wrap), 32'h0);
      chk("pri_load_ovf", 32'(if3.Overflow), 32'h1);
      if3.Load = 1'b0; if3.En = 1'b0; if3.ClrOvf = 1'b1;
      tick();
      chk("clr_alone", 32'(if3.Overflow), 32'h0);
      chk("clr_alone_out", 32'(if3.Output), 32'b110);
      if3.ClrOvf = 1'b0; if3.Load = 1'b1; if3.LoadVal = 3'b100;   // binary 7
      tick();
      chk("pri_load7", 32'(if3.Output), 32'b100);
      if3.Load = 1'b0; if3.En = 1'b1; if3.ClrOvf = 1'b1;
      tick();
      chk("clr_vs_wrap_out", 32'(if3.Output), 32'b000);
      chk("clr_vs_wrap_wrap", 32'(if3.Wrap), 32'h1);
      chk("clr_vs_wrap_ovf", 32'(if3.Overflow), 32'h1);
      if3.En = 1'b0;
      tick();
      chk("clr_again", 32'(if3.Overflow), 32'h0);
      chk("clr_again_wrap", 32'(if3.Wrap), 32'h0);
      if3.ClrOvf = 1'b0;

      // reset mid-count, WIDTH 8
      if8.En = 1'b1; if8.Up = 1'b1;
      repeat (37) tick();
      chk("w8_37", 32'(if8.Output), 32'h37);   // gray(37) = 0x25 ^ 0x12
      Reset = 1'b0;
      tick();
      chk("w8_rst_out", 32'(if8.Output), 32'h0);
      chk("w8_rst_ovf", 32'(if8.Overflow), 32'h0);
      chk("w8_rst_wrap", 32'(if8.Wrap), 32'h0);
      Reset = 1'b1;
      tick();
      chk("w8_resume", 32'(if8.Output), 32'h1);
      if8.En = 1'b0;

      // exhaustive Gray walk, WIDTH 5, starting from reset value 0
      begin
         int         m;
         int         pm;
         logic [4:0] prev;
         m = 0;
         prev = if5.Output;
         chk("w5_start", 32'(if5.Output), 32'h0);
         if5.En = 1'b1;
         for (int i = 0; i < 128; i++) begin
            if5.Up = (i < 64);
            pm = m;
            m = (i < 64) ? (m + 1) % 32 : (m + 31) % 32;
            tick();
            chk($sformatf("w5_ham[%0d]", i), 32'($countones(prev ^ if5.Output)), 32'h1);
            chk($sformatf("w5_bin[%0d]", i), 32'(ref5_bin), 32'(m));
            chk($sformatf("w5_wrap[%0d]", i), 32'(if5.Wrap),
                ((i < 64 && pm == 31) || (i >= 64 && pm == 0)) ? 32'h1 : 32'h0);
            prev = if5.Output;
         end
         if5.En = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end

endmodule
